// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and FIFO entry layout for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] CODE_BAT_OK  = 8'hAA;
  localparam logic [7:0] CODE_ERROR   = 8'hFF;
  localparam logic [7:0] CODE_EXTEND  = 8'hE0;
  localparam logic [7:0] CODE_RELEASE = 8'hF0;

  localparam int ENTRY_W  = 10;
  localparam int EXT_POS  = 9;
  localparam int REL_POS  = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic ext, input logic rel,
                                                    input logic [7:0] code);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[EXT_POS] = ext;
    e[REL_POS] = rel;
    e[CODE_MSB:CODE_LSB] = code;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is dropped and flagged.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO survives alongside it.
  assign do_pop  = rd_en && (count != '0);
  assign do_push = wr_en && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deframes bytes,
// folds E0/F0 prefixes into key-event entries and buffers them in a FWFT FIFO.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FILTER_LEN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic               reset_required,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic [FLT_W-1:0] flt_cnt;
  logic             clk_filt;
  logic             clk_filt_d;
  logic             fall;
  logic             data_bit;

  ps2_state_t       state;
  ps2_state_t       state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             ext_flag;
  logic             rel_flag;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout;

  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic               set_ext;
  logic               set_rel;
  logic               clr_flags;
  logic               parity_err_nxt;
  logic               frame_err_nxt;
  logic               reset_req_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered level flips only once FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_cnt    <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d && !clk_filt;
  assign data_bit = data_sync[1];
  assign timeout  = (state != ST_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE:   if (!data_bit) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Frame evaluation on the stop edge; a frame with both faults reports only parity.
  always_comb begin
    push           = 1'b0;
    push_data      = make_entry(ext_flag, rel_flag, shift_reg);
    set_ext        = 1'b0;
    set_rel        = 1'b0;
    clr_flags      = 1'b0;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    reset_req_nxt  = 1'b0;
    if (timeout) begin
      frame_err_nxt = 1'b1;
      clr_flags     = 1'b1;
    end else if ((state == ST_STOP) && fall) begin
      if (!(^{shift_reg, parity_bit})) begin
        parity_err_nxt = 1'b1;
        clr_flags      = 1'b1;
      end else if (!data_bit) begin
        frame_err_nxt = 1'b1;
        clr_flags     = 1'b1;
      end else begin
        case (shift_reg)
          CODE_EXTEND:  set_ext = 1'b1;
          CODE_RELEASE: set_rel = 1'b1;
          CODE_BAT_OK: begin
            reset_req_nxt = 1'b1;
            clr_flags     = 1'b1;
          end
          CODE_ERROR:   clr_flags = 1'b1;
          default: begin
            push      = 1'b1;
            clr_flags = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt        <= '0;
      shift_reg      <= '0;
      parity_bit     <= 1'b0;
      ext_flag       <= 1'b0;
      rel_flag       <= 1'b0;
      to_cnt         <= '0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      reset_required <= 1'b0;
    end else begin
      parity_err     <= parity_err_nxt;
      frame_err      <= frame_err_nxt;
      reset_required <= reset_req_nxt;
      to_cnt <= ((state == ST_IDLE) || fall || timeout) ? '0 : to_cnt + 1'b1;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (fall && (state == ST_DATA)) begin
        shift_reg <= {data_bit, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (fall && (state == ST_PARITY)) parity_bit <= data_bit;
      if (clr_flags) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else begin
        if (set_ext) ext_flag <= 1'b1;
        if (set_rel) rel_flag <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .overflow(overflow)
  );

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: drives PS/2 frames bit by bit and checks entries and pulses.
module tb_ps2_scan_receiver;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int FILTER_LEN     = 4;
  localparam int HALF           = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [9:0] rd_data;
  logic       empty;
  logic       full;
  logic       reset_required;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int par_cnt   = 0;
  int frm_cnt   = 0;
  int rr_cnt    = 0;
  int ovf_cnt   = 0;

  ps2_scan_receiver #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .reset_required(reset_required),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Pulse outputs are one cycle wide, so they are tallied for later comparison.
  always @(negedge clk) begin
    if (parity_err)     par_cnt <= par_cnt + 1;
    if (frame_err)      frm_cnt <= frm_cnt + 1;
    if (reset_required) rr_cnt  <= rr_cnt + 1;
    if (overflow)       ovf_cnt <= ovf_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    check_cnt = check_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("[TB] FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  task automatic apply_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] code, input logic flip_parity, input logic stop);
    logic par;
    par = ~(^code) ^ flip_parity;
    apply_bit(1'b0);
    for (int i = 0; i < 8; i++) apply_bit(code[i]);
    apply_bit(par);
    apply_bit(stop);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic send_good(input logic [7:0] code);
    apply_stimulus(code, 1'b0, 1'b1);
  endtask

  task automatic pop_entry();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(1);
  endtask

  task automatic wait_not_empty(input string tag);
    for (int i = 0; i < 400 && empty; i++) tick(1);
    check_output(tag, {9'd0, empty}, 10'h000);
  endtask

  initial begin
    // Reset state
    tick(3);
    check_output("reset_empty", {9'd0, empty}, 10'h001);
    check_output("reset_full", {9'd0, full}, 10'h000);
    check_output("reset_rd_data", rd_data, 10'h000);
    rst = 1'b1;
    tick(5);

    // Plain make code
    send_good(8'h1C);
    wait_not_empty("1c_arrives");
    check_output("1c_entry", rd_data, 10'h01C);
    pop_entry();
    check_output("1c_popped", {9'd0, empty}, 10'h001);

    // Read of an empty FIFO is ignored
    pop_entry();
    send_good(8'h1C);
    check_output("rd_empty_entry", rd_data, 10'h01C);
    pop_entry();
    check_output("rd_empty_drained", {9'd0, empty}, 10'h001);

    // Extended release sequence folds into one entry
    send_good(8'hE0);
    send_good(8'hF0);
    check_output("prefix_no_push", {9'd0, empty}, 10'h001);
    send_good(8'h75);
    check_output("ext_rel_entry", rd_data, 10'h375);
    pop_entry();
    check_output("ext_rel_single", {9'd0, empty}, 10'h001);

    // Parity failure
    apply_stimulus(8'h1C, 1'b1, 1'b1);
    check_output("parity_pulse", 10'(par_cnt), 10'd1);
    check_output("parity_no_push", {9'd0, empty}, 10'h001);

    // BAT completion clears the pending extended prefix
    send_good(8'hE0);
    send_good(8'hAA);
    check_output("bat_pulse", 10'(rr_cnt), 10'd1);
    check_output("bat_no_push", {9'd0, empty}, 10'h001);
    send_good(8'h1C);
    check_output("after_bat_entry", rd_data, 10'h01C);
    pop_entry();

    // Timeout after four data bits
    apply_bit(1'b0);
    apply_bit(1'b0);
    apply_bit(1'b0);
    apply_bit(1'b1);
    apply_bit(1'b1);
    ps2_data = 1'b1;
    tick(TIMEOUT_CYCLES + 20);
    check_output("timeout_pulse", 10'(frm_cnt), 10'd1);
    check_output("timeout_no_push", {9'd0, empty}, 10'h001);
    send_good(8'h1C);
    check_output("after_timeout_entry", rd_data, 10'h01C);
    pop_entry();

    // Bad stop bit, then a frame with both faults reports parity only
    apply_stimulus(8'h1C, 1'b0, 1'b0);
    check_output("stop_frame_pulse", 10'(frm_cnt), 10'd2);
    check_output("stop_no_parity", 10'(par_cnt), 10'd1);
    apply_stimulus(8'h1C, 1'b1, 1'b0);
    check_output("both_parity", 10'(par_cnt), 10'd2);
    check_output("both_no_frame", 10'(frm_cnt), 10'd2);

    // Bad frame clears a pending prefix
    send_good(8'hE0);
    apply_stimulus(8'h22, 1'b1, 1'b1);
    send_good(8'h1C);
    check_output("bad_clears_prefix", rd_data, 10'h01C);
    pop_entry();
    check_output("bad_clears_drained", {9'd0, empty}, 10'h001);

    // Fill to full and overflow
    send_good(8'h15);
    send_good(8'h1D);
    send_good(8'h24);
    check_output("three_not_full", {9'd0, full}, 10'h000);
    send_good(8'h2D);
    check_output("four_full", {9'd0, full}, 10'h001);
    check_output("no_ovf_yet", 10'(ovf_cnt), 10'd0);
    send_good(8'h2C);
    check_output("ovf_pulse", 10'(ovf_cnt), 10'd1);
    check_output("ovf_still_full", {9'd0, full}, 10'h001);
    check_output("fifo_head0", rd_data, 10'h015);
    pop_entry();
    check_output("pop_not_full", {9'd0, full}, 10'h000);
    check_output("fifo_head1", rd_data, 10'h01D);
    pop_entry();
    check_output("fifo_head2", rd_data, 10'h024);
    pop_entry();
    check_output("fifo_head3", rd_data, 10'h02D);
    pop_entry();
    check_output("fifo_drained", {9'd0, empty}, 10'h001);

    // Short low glitch on ps2_clk in idle must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(FILTER_LEN - 1);
    ps2_clk  = 1'b1;
    tick(HALF);
    ps2_data = 1'b1;
    tick(HALF);
    send_good(8'h1C);
    check_output("glitch_entry", rd_data, 10'h01C);
    pop_entry();
    check_output("glitch_single", {9'd0, empty}, 10'h001);

    // Reset in the middle of a frame discards it
    apply_bit(1'b0);
    apply_bit(1'b1);
    apply_bit(1'b1);
    ps2_data = 1'b1;
    rst = 1'b0;
    tick(3);
    check_output("midreset_empty", {9'd0, empty}, 10'h001);
    rst = 1'b1;
    tick(5);
    send_good(8'h1C);
    check_output("midreset_entry", rd_data, 10'h01C);
    check_output("midreset_no_frame_err", 10'(frm_cnt), 10'd2);
    pop_entry();
    check_output("midreset_drained", {9'd0, empty}, 10'h001);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
